scsp_lfo_gen: RTL and testbench

- Time-multiplexed low-frequency oscillator engine for the sound-slot pipeline.
- Holds a divider counter and an 8-bit phase for each of NUM_SLOTS slots.
- Each time the slot sequencer presents a slot, the block produces that slot's amplitude-LFO (ALFO) and pitch-LFO (PLFO) values and advances the slot's state by one sample.
- Beyond a single fixed 32-slot LFO, it adds a parametrised slot count, an internal noise LFSR and a global phase-sync input.

---
 rtl/scsp_lfo_gen.sv | 149 ++++++++++++++
 tb/tb_scsp_lfo_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/scsp_lfo_gen.sv
// Time-multiplexed ALFO/PLFO engine: per-slot divider and 8-bit phase, shared noise LFSR,
// one-cycle registered outputs for each presented slot.
module scsp_lfo_gen #(
    parameter int          NUM_SLOTS  = 32,
    parameter int          SLOT_W     = $clog2(NUM_SLOTS),
    parameter logic [16:0] NOISE_SEED = 17'h1ACE1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic              SLOT_VAL,
    input  logic [SLOT_W-1:0] SLOT_IN,
    input  logic              LFORE,
    input  logic [4:0]        LFOF,
    input  logic [1:0]        ALFOWS,
    input  logic [2:0]        ALFOS,
    input  logic [1:0]        PLFOWS,
    input  logic [2:0]        PLFOS,
    input  logic              SYNC,
    output logic              OUT_VAL,
    output logic [SLOT_W-1:0] OUT_SLOT,
    output logic [7:0]        ALFO_OUT,
    output logic [7:0]        PLFO_OUT
);

    function automatic logic [9:0] reload_f(input logic [4:0] f);
        logic [10:0] base;
        base = (11'd8 - {9'd0, f[1:0]}) << 7;
        base = base >> f[4:2];
        return 10'(base - 11'd5);
    endfunction

    function automatic logic [7:0] alfo_f(input logic [1:0] ws, input logic [2:0] depth,
                                          input logic [7:0] p, input logic [7:0] noise);
        logic [7:0] w;
        case (ws)
            2'd0:    w = p;
            2'd1:    w = {8{p[7]}};
            2'd2:    w = {p[6:0] ^ {7{p[7]}}, 1'b0};
            default: w = noise;
        endcase
        if (depth == 3'd0) return 8'd0;
        return w >> (3'd7 - depth);
    endfunction

    function automatic logic signed [7:0] plfo_f(input logic [1:0] ws, input logic [2:0] depth,
                                                 input logic [7:0] p, input logic [7:0] noise);
        logic signed [7:0] w;
        case (ws)
            2'd0:    w = p;
            2'd1:    w = {p[7], {7{~p[7]}}};
            2'd2:    w = {({1'b0, p[5:0] ^ {6{p[6]}}}) ^ {7{p[7]}}, 1'b0};
            default: w = noise;
        endcase
        if (depth == 3'd0) return 8'sd0;
        return w >>> (3'd7 - depth);
    endfunction

    logic [7:0]        phase_q [NUM_SLOTS];
    logic [7:0]        phase_d [NUM_SLOTS];
    logic [9:0]        cnt_q   [NUM_SLOTS];
    logic [9:0]        cnt_d   [NUM_SLOTS];
    logic [16:0]       lfsr_q, lfsr_d;
    logic              out_val_q, out_val_d;
    logic [SLOT_W-1:0] out_slot_q, out_slot_d;
    logic [7:0]        alfo_q, alfo_d;
    logic signed [7:0] plfo_q, plfo_d;

    logic              slot_ok;
    logic              strobe;
    logic [7:0]        cur_phase;
    logic [9:0]        cur_cnt;
    logic [7:0]        p_eff;
    logic [9:0]        reload;

    // Stage 0: read slot state, form waves, compute next state
    always_comb begin
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        out_val_d  = out_val_q;
        out_slot_d = out_slot_q;
        alfo_d     = alfo_q;
        plfo_d     = plfo_q;

        slot_ok   = {1'b0, SLOT_IN} < (SLOT_W + 1)'(NUM_SLOTS);
        strobe    = CE & SLOT_VAL & slot_ok;
        cur_phase = phase_q[SLOT_IN];
        cur_cnt   = cnt_q[SLOT_IN];
        p_eff     = (SYNC | LFORE) ? 8'd0 : cur_phase;
        reload    = reload_f(LFOF);

        if (CE) begin
            out_val_d = strobe;
            if (strobe) begin
                out_slot_d = SLOT_IN;
                alfo_d     = alfo_f(ALFOWS, ALFOS, p_eff, lfsr_q[7:0]);
                plfo_d     = plfo_f(PLFOWS, PLFOS, p_eff, lfsr_q[7:0]);
                lfsr_d     = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
            end
            // SYNC wins over the slot update, so a slot strobed with SYNC stays cleared
            if (SYNC) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    phase_d[i] = 8'd0;
                    cnt_d[i]   = 10'd0;
                end
            end else if (strobe) begin
                if (LFORE) begin
                    phase_d[SLOT_IN] = 8'd0;
                    cnt_d[SLOT_IN]   = reload;
                end else if (cur_cnt == 10'd0) begin
                    phase_d[SLOT_IN] = cur_phase + 8'd1;
                    cnt_d[SLOT_IN]   = reload;
                end else begin
                    cnt_d[SLOT_IN]   = cur_cnt - 10'd1;
                end
            end
        end
    end

    // Stage 1: registered state and outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                phase_q[i] <= 8'd0;
                cnt_q[i]   <= 10'd0;
            end
            lfsr_q     <= NOISE_SEED;
            out_val_q  <= 1'b0;
            out_slot_q <= '0;
            alfo_q     <= 8'd0;
            plfo_q     <= 8'sd0;
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            out_val_q  <= out_val_d;
            out_slot_q <= out_slot_d;
            alfo_q     <= alfo_d;
            plfo_q     <= plfo_d;
        end
    end

    assign OUT_VAL  = out_val_q;
    assign OUT_SLOT = out_slot_q;
    assign ALFO_OUT = alfo_q;
    assign PLFO_OUT = plfo_q;

endmodule

// File: tb/tb_scsp_lfo_gen.sv
// Directed bench for scsp_lfo_gen: a plain-arithmetic slot model checked every cycle,
// plus literal expectations from hand calculation.
module tb_scsp_lfo_gen;

    localparam int NUM    = 32;
    localparam int SW     = 5;
    localparam logic [16:0] SEED = 17'h1ACE1;

    logic          CLK = 1'b0;
    logic          RST, CE, SLOT_VAL, LFORE, SYNC;
    logic [SW-1:0] SLOT_IN;
    logic [4:0]    LFOF;
    logic [1:0]    ALFOWS, PLFOWS;
    logic [2:0]    ALFOS, PLFOS;
    logic          OUT_VAL;
    logic [SW-1:0] OUT_SLOT;
    logic [7:0]    ALFO_OUT, PLFO_OUT;

    scsp_lfo_gen #(.NUM_SLOTS(NUM), .SLOT_W(SW), .NOISE_SEED(SEED)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .SLOT_VAL(SLOT_VAL), .SLOT_IN(SLOT_IN),
        .LFORE(LFORE), .LFOF(LFOF), .ALFOWS(ALFOWS), .ALFOS(ALFOS),
        .PLFOWS(PLFOWS), .PLFOS(PLFOS), .SYNC(SYNC), .OUT_VAL(OUT_VAL),
        .OUT_SLOT(OUT_SLOT), .ALFO_OUT(ALFO_OUT), .PLFO_OUT(PLFO_OUT)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mphase [NUM];
    int mcnt   [NUM];
    logic [16:0] mlfsr;
    int exp_val = 0, exp_slot = 0, exp_alfo = 0, exp_plfo = 0;

    function automatic int reload_m(input int f);
        return ((8 - (f % 4)) * 128) / (1 << (f / 4)) - 5;
    endfunction

    function automatic int alfo_m(input int ws, input int depth, input int p, input int noise);
        int w;
        case (ws)
            0: w = p;
            1: w = (p >= 128) ? 255 : 0;
            2: w = (p < 128) ? 2 * p : 2 * (255 - p);
            default: w = noise;
        endcase
        if (depth == 0) return 0;
        return w / (1 << (7 - depth));
    endfunction

    function automatic int plfo_m(input int ws, input int depth, input int p, input int noise);
        int w, q;
        case (ws)
            0: w = p;
            1: w = (p >= 128) ? 128 : 127;
            2: begin
                q = p % 64;
                if ((p / 64) % 2 == 1) q = 63 - q;
                if (p >= 128) q = 127 - q;
                w = 2 * q;
            end
            default: w = noise;
        endcase
        if (depth == 0) return 0;
        if (w >= 128) w = w - 256;
        return (w >>> (7 - depth)) & 255;
    endfunction

    always @(posedge CLK) begin
        int s, p, r;
        if (RST) begin
            for (int i = 0; i < NUM; i++) begin mphase[i] = 0; mcnt[i] = 0; end
            mlfsr = SEED;
            exp_val = 0; exp_slot = 0; exp_alfo = 0; exp_plfo = 0;
        end else if (CE) begin
            s = int'(SLOT_IN);
            if (SLOT_VAL && s < NUM) begin
                p = (SYNC || LFORE) ? 0 : mphase[s];
                r = reload_m(int'(LFOF));
                exp_val  = 1;
                exp_slot = s;
                exp_alfo = alfo_m(int'(ALFOWS), int'(ALFOS), p, int'(mlfsr[7:0]));
                exp_plfo = plfo_m(int'(PLFOWS), int'(PLFOS), p, int'(mlfsr[7:0]));
                mlfsr = {mlfsr[15:0], mlfsr[16] ^ mlfsr[13]};
                if (!SYNC) begin
                    if (LFORE) begin mphase[s] = 0; mcnt[s] = r; end
                    else if (mcnt[s] == 0) begin mphase[s] = (mphase[s] + 1) % 256; mcnt[s] = r; end
                    else mcnt[s] = mcnt[s] - 1;
                end
            end else begin
                exp_val = 0;
            end
            if (SYNC) for (int i = 0; i < NUM; i++) begin mphase[i] = 0; mcnt[i] = 0; end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model OUT_VAL", int'(OUT_VAL), exp_val);
            chk("model OUT_SLOT", int'(OUT_SLOT), exp_slot);
            chk("model ALFO_OUT", int'(ALFO_OUT), exp_alfo);
            chk("model PLFO_OUT", int'(PLFO_OUT), exp_plfo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic strobe(input int s, input bit lfore, input bit sync);
        @(negedge CLK);
        CE = 1; SLOT_VAL = 1; SLOT_IN = SW'(s); LFORE = lfore; SYNC = sync;
        @(posedge CLK); #1;
        SLOT_VAL = 0; LFORE = 0; SYNC = 0;
    endtask

    task automatic idle();
        @(negedge CLK);
        CE = 1; SLOT_VAL = 0;
        @(posedge CLK); #1;
    endtask

    task automatic set_waves(input int aw, input int as, input int pw, input int ps);
        ALFOWS = 2'(aw); ALFOS = 3'(as); PLFOWS = 2'(pw); PLFOS = 3'(ps);
    endtask

    initial begin
        RST = 1; CE = 1; SLOT_VAL = 0; SLOT_IN = '0; LFORE = 0; SYNC = 0;
        LFOF = 5'd31; set_waves(0, 7, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("reset OUT_VAL", int'(OUT_VAL), 0);
        chk("reset ALFO_OUT", int'(ALFO_OUT), 0);
        chk("reset PLFO_OUT", int'(PLFO_OUT), 0);
        @(negedge CLK); RST = 0;
        chk_en = 1;

        // saw ramp on slot 2, fastest rate
        for (int i = 0; i < 4; i++) begin
            strobe(2, 0, 0);
            chk("saw ALFO", int'(ALFO_OUT), i);
            chk("saw OUT_SLOT", int'(OUT_SLOT), 2);
            chk("saw OUT_VAL", int'(OUT_VAL), 1);
            chk("saw PLFO depth0", int'(PLFO_OUT), 0);
        end
        @(negedge CLK); CE = 0; SLOT_VAL = 1; SLOT_IN = 5'd3;
        @(posedge CLK); #1;
        chk("CE=0 OUT_VAL hold", int'(OUT_VAL), 1);
        chk("CE=0 ALFO hold", int'(ALFO_OUT), 3);
        SLOT_VAL = 0;
        idle();
        chk("idle OUT_VAL", int'(OUT_VAL), 0);
        chk("idle ALFO hold", int'(ALFO_OUT), 3);

        // slowest divider on slot 5: period 1020 strobes
        LFOF = 5'd0;
        for (int i = 1; i <= 1022; i++) begin
            strobe(5, 0, 0);
            if (i == 1)    chk("div strobe1", int'(ALFO_OUT), 0);
            if (i == 2)    chk("div strobe2", int'(ALFO_OUT), 1);
            if (i == 1021) chk("div strobe1021", int'(ALFO_OUT), 1);
            if (i == 1022) chk("div strobe1022", int'(ALFO_OUT), 2);
        end

        // phase wrap on slot 6, then LFO reset
        LFOF = 5'd31;
        for (int i = 1; i <= 257; i++) begin
            strobe(6, 0, 0);
            if (i == 256) chk("wrap 0xFF", int'(ALFO_OUT), 8'hFF);
            if (i == 257) chk("wrap 0x00", int'(ALFO_OUT), 0);
        end
        strobe(6, 1, 0);
        chk("LFORE out", int'(ALFO_OUT), 0);
        strobe(6, 0, 0);
        chk("after LFORE 0", int'(ALFO_OUT), 0);
        strobe(6, 0, 0);
        chk("after LFORE 1", int'(ALFO_OUT), 1);

        // waveform shapes
        for (int i = 0; i < 128; i++) strobe(1, 0, 0);
        set_waves(1, 4, 2, 7);
        strobe(1, 0, 0);
        chk("square ALFO 0x80", int'(ALFO_OUT), 8'h1F);
        chk("tri PLFO 0x80", int'(PLFO_OUT), 8'hFE);
        for (int i = 0; i < 64; i++) strobe(7, 0, 0);
        strobe(7, 0, 0);
        chk("tri PLFO 0x40", int'(PLFO_OUT), 8'h7E);
        set_waves(2, 7, 1, 1);
        for (int i = 0; i < 16; i++) strobe(8, 0, 0);
        strobe(8, 0, 0);
        chk("sq PLFO 0x10", int'(PLFO_OUT), 8'h01);
        for (int i = 0; i < 144; i++) strobe(9, 0, 0);
        strobe(9, 0, 0);
        chk("sq PLFO 0x90", int'(PLFO_OUT), 8'hFE);

        // SYNC with a simultaneous strobe; PLFO carries noise across it
        set_waves(0, 7, 3, 7);
        for (int i = 0; i < 32; i++) begin strobe(0, 0, 0); strobe(3, 0, 0); end
        chk("pre-sync phase", int'(ALFO_OUT), 8'h1F);
        strobe(3, 0, 1);
        chk("sync out", int'(ALFO_OUT), 0);
        strobe(0, 0, 0); chk("sync s0 a", int'(ALFO_OUT), 0);
        strobe(3, 0, 0); chk("sync s3 a", int'(ALFO_OUT), 0);
        strobe(0, 0, 0); chk("sync s0 b", int'(ALFO_OUT), 1);
        strobe(3, 0, 0); chk("sync s3 b", int'(ALFO_OUT), 1);

        // reset right after a strobe
        strobe(4, 0, 0);
        @(negedge CLK); RST = 1;
        @(posedge CLK); #1;
        chk("mid RST OUT_VAL", int'(OUT_VAL), 0);
        chk("mid RST ALFO", int'(ALFO_OUT), 0);
        chk("mid RST PLFO", int'(PLFO_OUT), 0);
        chk("mid RST OUT_SLOT", int'(OUT_SLOT), 0);
        @(negedge CLK); RST = 0;
        set_waves(3, 7, 3, 7);
        strobe(2, 0, 0);
        chk("seed noise ALFO", int'(ALFO_OUT), 8'hE1);
        chk("seed noise PLFO", int'(PLFO_OUT), 8'hE1);
        set_waves(0, 7, 0, 7);
        strobe(0, 0, 0); chk("post RST s0", int'(ALFO_OUT), 0);
        strobe(1, 0, 0); chk("post RST s1", int'(ALFO_OUT), 0);
        strobe(9, 0, 0); chk("post RST s9", int'(PLFO_OUT), 0);
        idle();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
